merge_stream_fifo: RTL and testbench

Four-to-one packet merger: each of four AXI-Stream inputs is buffered in its own FIFO, and a packet-level round-robin arbiter forwards whole packets, never interleaved, onto one output stream tagged with the source port index. It is the gather-side counterpart of the split/FIFO fan-out in the RFNoC stream library. It recombines per-channel streams, such as replies from parallel processing lanes, into a single stream for a crossbar port or a DMA.

---
 rtl/merge_stream_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_merge_stream_fifo.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_stream_fifo.sv
// merge_stream_fifo: four per-port input FIFOs merged into one stream
// by a packet-level round-robin arbiter, tagged with the source index.
module merge_stream_fifo #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FIFO_SIZE   = 5,
  parameter logic [3:0]  ACTIVE_MASK = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  input  logic [WIDTH-1:0] i2_tdata,
  input  logic             i2_tlast,
  input  logic             i2_tvalid,
  output logic             i2_tready,
  input  logic [WIDTH-1:0] i3_tdata,
  input  logic             i3_tlast,
  input  logic             i3_tvalid,
  output logic             i3_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [1:0]       o_tsrc
);

  localparam int unsigned DEPTH = 1 << FIFO_SIZE;

  typedef enum logic {
    IDLE,
    PASS
  } state_e;

  logic flush;
  assign flush = !reset || clear;

  logic [WIDTH-1:0] in_data [4];
  logic [3:0]       in_last;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;

  logic [WIDTH-1:0] f_data [4];
  logic [3:0]       f_last;
  logic [3:0]       f_valid;
  logic [3:0]       f_pop;

  assign in_data[0] = i0_tdata;
  assign in_data[1] = i1_tdata;
  assign in_data[2] = i2_tdata;
  assign in_data[3] = i3_tdata;
  assign in_last    = {i3_tlast, i2_tlast,
                       i1_tlast, i0_tlast};
  assign in_valid   = {i3_tvalid, i2_tvalid,
                       i1_tvalid, i0_tvalid};

  assign i0_tready = in_ready[0];
  assign i1_tready = in_ready[1];
  assign i2_tready = in_ready[2];
  assign i3_tready = in_ready[3];

  for (genvar k = 0; k < 4; k++) begin : g_port
    if (ACTIVE_MASK[k]) begin : g_fifo
      localparam logic [FIFO_SIZE-1:0] PTR_ONE = 1;
      localparam logic [FIFO_SIZE:0]   CNT_ONE = 1;

      logic [WIDTH:0]       mem_q [DEPTH];
      logic [FIFO_SIZE-1:0] wr_q;
      logic [FIFO_SIZE-1:0] wr_d;
      logic [FIFO_SIZE-1:0] rd_q;
      logic [FIFO_SIZE-1:0] rd_d;
      logic [FIFO_SIZE:0]   cnt_q;
      logic [FIFO_SIZE:0]   cnt_d;
      logic                 push;

      // Count reaches DEPTH only when its top bit is set.
      assign in_ready[k] = reset && !clear
                           && !cnt_q[FIFO_SIZE];
      assign push        = in_valid[k] && in_ready[k];
      assign f_valid[k]  = (cnt_q != '0);
      assign {f_last[k], f_data[k]} = mem_q[rd_q];

      // Pointer and occupancy next-state.
      always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
          wr_d = wr_q + PTR_ONE;
        end
        if (f_pop[k]) begin
          rd_d = rd_q + PTR_ONE;
        end
        unique case ({push, f_pop[k]})
          2'b10:   cnt_d = cnt_q + CNT_ONE;
          2'b01:   cnt_d = cnt_q - CNT_ONE;
          default: cnt_d = cnt_q;
        endcase
      end

      // Pointer and occupancy registers.
      always_ff @(posedge clk) begin
        if (flush) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          wr_q  <= wr_d;
          rd_q  <= rd_d;
          cnt_q <= cnt_d;
        end
      end

      // Storage; contents are meaningless while empty.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_q] <= {in_last[k], in_data[k]};
        end
      end
    end else begin : g_off
      logic unused_k;
      assign unused_k = ^{in_data[k], in_last[k],
                          in_valid[k], f_pop[k]};
      assign in_ready[k] = 1'b0;
      assign f_valid[k]  = 1'b0;
      assign f_last[k]   = 1'b0;
      assign f_data[k]   = '0;
    end
  end

  state_e     state_q;
  state_e     state_d;
  logic [1:0] grant_q;
  logic [1:0] grant_d;
  logic [1:0] last_q;
  logic [1:0] last_d;
  logic       hit;
  logic [1:0] pick;
  logic [1:0] cand;

  // Rotating search starting just after the last served port.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!hit && f_valid[cand]
          && ACTIVE_MASK[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  // Arbiter next-state and FIFO pop.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    f_pop   = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          grant_d = pick;
          state_d = PASS;
        end
      end
      PASS: begin
        if (f_valid[grant_q] && o_tready) begin
          f_pop[grant_q] = 1'b1;
          if (f_last[grant_q]) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter registers; port 0 has first priority after flush.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign o_tvalid = (state_q == PASS)
                    && f_valid[grant_q];
  assign o_tdata  = f_data[grant_q];
  assign o_tlast  = f_last[grant_q];
  assign o_tsrc   = grant_q;

endmodule

// File: tb/tb_merge_stream_fifo.sv
// tb_merge_stream_fifo: queue-based packet model checked every cycle,
// plus directed latency, round-robin, stall, mask and clear vectors.
module tb_merge_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [2:0]            clr;
  logic [2:0]            ordy;
  logic [2:0][3:0][15:0] td;
  logic [2:0][3:0]       tl;
  logic [2:0][3:0]       tv;
  wire  [2:0][3:0]       tr;
  wire  [2:0][15:0]      od;
  wire  [2:0]            ol;
  wire  [2:0]            ov;
  wire  [2:0][1:0]       os;

  merge_stream_fifo u0 (
    .clk(clk), .reset(reset), .clear(clr[0]),
    .i0_tdata(td[0][0]), .i0_tlast(tl[0][0]),
    .i0_tvalid(tv[0][0]), .i0_tready(tr[0][0]),
    .i1_tdata(td[0][1]), .i1_tlast(tl[0][1]),
    .i1_tvalid(tv[0][1]), .i1_tready(tr[0][1]),
    .i2_tdata(td[0][2]), .i2_tlast(tl[0][2]),
    .i2_tvalid(tv[0][2]), .i2_tready(tr[0][2]),
    .i3_tdata(td[0][3]), .i3_tlast(tl[0][3]),
    .i3_tvalid(tv[0][3]), .i3_tready(tr[0][3]),
    .o_tdata(od[0]), .o_tlast(ol[0]),
    .o_tvalid(ov[0]), .o_tready(ordy[0]),
    .o_tsrc(os[0])
  );

  merge_stream_fifo #(.FIFO_SIZE(2)) u1 (
    .clk(clk), .reset(reset), .clear(clr[1]),
    .i0_tdata(td[1][0]), .i0_tlast(tl[1][0]),
    .i0_tvalid(tv[1][0]), .i0_tready(tr[1][0]),
    .i1_tdata(td[1][1]), .i1_tlast(tl[1][1]),
    .i1_tvalid(tv[1][1]), .i1_tready(tr[1][1]),
    .i2_tdata(td[1][2]), .i2_tlast(tl[1][2]),
    .i2_tvalid(tv[1][2]), .i2_tready(tr[1][2]),
    .i3_tdata(td[1][3]), .i3_tlast(tl[1][3]),
    .i3_tvalid(tv[1][3]), .i3_tready(tr[1][3]),
    .o_tdata(od[1]), .o_tlast(ol[1]),
    .o_tvalid(ov[1]), .o_tready(ordy[1]),
    .o_tsrc(os[1])
  );

  merge_stream_fifo #(.ACTIVE_MASK(4'b0101)) u2 (
    .clk(clk), .reset(reset), .clear(clr[2]),
    .i0_tdata(td[2][0]), .i0_tlast(tl[2][0]),
    .i0_tvalid(tv[2][0]), .i0_tready(tr[2][0]),
    .i1_tdata(td[2][1]), .i1_tlast(tl[2][1]),
    .i1_tvalid(tv[2][1]), .i1_tready(tr[2][1]),
    .i2_tdata(td[2][2]), .i2_tlast(tl[2][2]),
    .i2_tvalid(tv[2][2]), .i2_tready(tr[2][2]),
    .i3_tdata(td[2][3]), .i3_tlast(tl[2][3]),
    .i3_tvalid(tv[2][3]), .i3_tready(tr[2][3]),
    .o_tdata(od[2]), .o_tlast(ol[2]),
    .o_tvalid(ov[2]), .o_tready(ordy[2]),
    .o_tsrc(os[2])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: per-port queues of accepted beats, packet-level grant.
  int          dep [3] = '{32, 4, 32};
  logic [3:0]  msk [3] = '{4'hF, 4'hF, 4'h5};
  logic [16:0] mq  [3][4][32];
  int          mrd [3][4];
  int          mcnt[3][4];
  int          mg  [3];
  int          ml  [3];
  int          ms  [3];
  int          srclog[$];
  int          outb1 = 0;

  task automatic mreset(input int n);
    for (int k = 0; k < 4; k++) begin
      mrd[n][k]  = 0;
      mcnt[n][k] = 0;
    end
    mg[n] = -1;
    ml[n] = 3;
    ms[n] = 0;
  endtask

  initial begin
    int          g;
    int          idx;
    bit          ev;
    logic [3:0]  er;
    logic [16:0] h;
    for (int n = 0; n < 3; n++) mreset(n);
    forever begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        g  = mg[n];
        ev = (g >= 0) && (mcnt[n][g] > 0);
        h  = '0;
        if (ev) h = mq[n][g][mrd[n][g]];
        chk($sformatf("u%0d_valid", n),
            32'(ov[n]), 32'(ev));
        if (ev) begin
          chk($sformatf("u%0d_data", n),
              32'(od[n]), 32'(h[15:0]));
          chk($sformatf("u%0d_last", n),
              32'(ol[n]), 32'(h[16]));
        end
        chk($sformatf("u%0d_src", n),
            32'(os[n]), 32'(ms[n]));
        for (int k = 0; k < 4; k++) begin
          er[k] = msk[n][k] && reset && !clr[n]
                  && (mcnt[n][k] < dep[n]);
        end
        chk($sformatf("u%0d_tready", n),
            32'(tr[n]), 32'(er));
        if (n == 1 && ov[1] && ordy[1]) outb1++;
        if (!reset || clr[n]) begin
          mreset(n);
        end else begin
          if (g < 0) begin
            for (int i = 1; i <= 4; i++) begin
              idx = (ml[n] + i) % 4;
              if (mg[n] < 0 && msk[n][idx]
                  && mcnt[n][idx] > 0) begin
                mg[n] = idx;
                ms[n] = idx;
                if (n == 0) srclog.push_back(idx);
              end
            end
          end else if (ev && ordy[n]) begin
            mrd[n][g] = (mrd[n][g] + 1) % 32;
            mcnt[n][g]--;
            if (h[16]) begin
              ml[n] = g;
              mg[n] = -1;
            end
          end
          for (int k = 0; k < 4; k++) begin
            if (tv[n][k] && er[k]) begin
              idx = (mrd[n][k] + mcnt[n][k]) % 32;
              mq[n][k][idx] = {tl[n][k], td[n][k]};
              mcnt[n][k]++;
            end
          end
        end
      end
    end
  end

  // One beat on input k of instance n, waiting for its handshake.
  task automatic beat(input int n, input int k,
                      input logic [15:0] d,
                      input logic l);
    bit ok;
    ok = 1'b0;
    td[n][k] = d;
    tl[n][k] = l;
    tv[n][k] = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = tr[n][k];
      @(posedge clk);
      #1;
    end
    tv[n][k] = 1'b0;
    tl[n][k] = 1'b0;
    chk("push_handshake", 32'(ok), 32'd1);
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  int acc;

  initial begin
    reset = 1'b0;
    clr   = '0;
    ordy  = '0;
    td    = '0;
    tl    = '0;
    tv    = '0;

    repeat (4) begin
      @(negedge clk);
      chk("rst_tready", 32'(tr), 32'd0);
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_src", 32'(os), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_tready_u0", 32'(tr[0]), 32'hF);
    chk("rel_tready_u1", 32'(tr[1]), 32'hF);
    chk("mask_tready", 32'(tr[2]), 32'h5);

    // Latency: 3-beat packet on i2.
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    td[0][2] = 16'h0001;
    tv[0][2] = 1'b1;
    @(negedge clk);
    chk("lat_pre", 32'(ov[0]), 32'd0);
    @(posedge clk);
    #1;
    td[0][2] = 16'h0002;
    @(negedge clk);
    chk("lat_n1", 32'(ov[0]), 32'd0);
    @(posedge clk);
    #1;
    td[0][2] = 16'h0003;
    tl[0][2] = 1'b1;
    @(negedge clk);
    chk("lat_n2_v", 32'(ov[0]), 32'd1);
    chk("lat_n2_d", 32'(od[0]), 32'h0001);
    chk("lat_n2_s", 32'(os[0]), 32'd2);
    @(posedge clk);
    #1;
    tv[0][2] = 1'b0;
    tl[0][2] = 1'b0;
    @(negedge clk);
    chk("lat_n3_d", 32'(od[0]), 32'h0002);
    chk("lat_n3_l", 32'(ol[0]), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_n4_d", 32'(od[0]), 32'h0003);
    chk("lat_n4_l", 32'(ol[0]), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_n5_v", 32'(ov[0]), 32'd0);
    @(posedge clk);
    #1;

    // Round robin from a preloaded, stalled state.
    ordy[0] = 1'b0;
    srclog.delete();
    for (int k = 0; k < 4; k++) begin
      beat(0, k, 16'(16 * k + 1), 1'b0);
      beat(0, k, 16'(16 * k + 2), 1'b1);
    end
    beat(0, 0, 16'h00A1, 1'b0);
    beat(0, 0, 16'h00A2, 1'b1);
    beat(0, 1, 16'h00B1, 1'b0);
    beat(0, 1, 16'h00B2, 1'b1);
    ordy[0] = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("rr_count", 32'(srclog.size()), 32'd6);
    for (int i = 0; i < 6 && i < srclog.size(); i++)
      chk($sformatf("rr_order%0d", i),
          32'(srclog[i]), 32'(rr_exp[i]));

    // No interleave: i1 starves mid-packet.
    srclog.delete();
    beat(0, 1, 16'h1001, 1'b0);
    beat(0, 1, 16'h1002, 1'b0);
    beat(0, 0, 16'h0501, 1'b0);
    beat(0, 0, 16'h0502, 1'b1);
    @(negedge clk);
    chk("ni_gap_valid", 32'(ov[0]), 32'd0);
    chk("ni_gap_src", 32'(os[0]), 32'd1);
    @(posedge clk);
    #1;
    beat(0, 1, 16'h1003, 1'b0);
    beat(0, 1, 16'h1004, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("ni_count", 32'(srclog.size()), 32'd2);
    if (srclog.size() == 2) begin
      chk("ni_first", 32'(srclog[0]), 32'd1);
      chk("ni_second", 32'(srclog[1]), 32'd0);
    end

    // Backpressure on a 4-deep FIFO, then random ready.
    ordy[1] = 1'b0;
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      if (c >= 8) ordy[1] = 1'($urandom_range(0, 1));
      if (acc < 6) begin
        td[1][3] = 16'(32'h3001 + acc);
        tl[1][3] = (acc == 2) || (acc == 5);
        tv[1][3] = 1'b1;
      end else begin
        tv[1][3] = 1'b0;
        tl[1][3] = 1'b0;
      end
      @(negedge clk);
      if (tv[1][3] && tr[1][3]) acc++;
      if (c == 7) begin
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_full_ready", 32'(tr[1][3]), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    tv[1][3] = 1'b0;
    ordy[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_all_in", 32'(acc), 32'd6);
    chk("bp_all_out", 32'(outb1), 32'd6);

    // Masked ports and a clear mid-packet.
    ordy[2]  = 1'b1;
    td[2][1] = 16'h0BAD;
    tl[2][1] = 1'b1;
    tv[2][1] = 1'b1;
    beat(2, 0, 16'h2001, 1'b0);
    beat(2, 0, 16'h2002, 1'b0);
    clr[2] = 1'b1;
    @(negedge clk);
    chk("clr_i1_ready", 32'(tr[2][1]), 32'd0);
    @(posedge clk);
    #1;
    clr[2] = 1'b0;
    @(negedge clk);
    chk("clr_valid", 32'(ov[2]), 32'd0);
    chk("clr_tready", 32'(tr[2]), 32'h5);
    @(posedge clk);
    #1;
    beat(2, 2, 16'h2201, 1'b0);
    beat(2, 2, 16'h2202, 1'b1);
    acc = 0;
    for (int t = 0; t < 20 && acc == 0; t++) begin
      @(negedge clk);
      if (ov[2]) acc = 1;
    end
    chk("mc_valid", 32'(ov[2]), 32'd1);
    chk("mc_src", 32'(os[2]), 32'd2);
    chk("mc_data", 32'(od[2]), 32'h2201);
    @(posedge clk);
    #1;
    tv[2][1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
